// File: rtl/furv_pkg.sv
// furv_pkg: shared core constants, register-index type and the round-robin
// pointer update helper used by the write-back arbiter.
package furv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned MAX_REQ   = 8;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    // Next round-robin pointer: one past the granted index (mod n), or the
    // current pointer when nothing was granted. grant is one-hot, zero-padded.
    function automatic int unsigned rr_next(int unsigned ptr,
                                            logic [MAX_REQ-1:0] grant,
                                            int unsigned n);
        int unsigned nxt;
        nxt = ptr;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (grant[i]) begin
                nxt = (i + 1 >= n) ? 0 : i + 1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/furv_wb_arb_if.sv
// furv_wb_arb_if: requester-side handshake and register-file write/release
// signals of the write-back arbiter. master = producers/register file side,
// slave = arbiter.
interface furv_wb_arb_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = furv_pkg::XLEN
);
    import furv_pkg::*;

    logic [NREQ-1:0]           req_valid;
    logic [REG_IDX_W*NREQ-1:0] req_rd;
    logic [XLEN*NREQ-1:0]      req_value;
    logic [NREQ-1:0]           req_ready;
    reg_idx_t                  wb_rel_rd;
    logic [XLEN-1:0]           wb_rd_value;
    logic                      wb_rd_ready;
    logic                      err_dup_rd;

    modport master (
        output req_valid, req_rd, req_value,
        input  req_ready, wb_rel_rd, wb_rd_value, wb_rd_ready, err_dup_rd
    );

    modport slave (
        input  req_valid, req_rd, req_value,
        output req_ready, wb_rel_rd, wb_rd_value, wb_rd_ready, err_dup_rd
    );

endinterface

// File: rtl/furv_rr_pick.sv
// furv_rr_pick: combinational rotate-priority encoder. Search starts at ptr
// and wraps upward modulo NREQ; the first valid requester wins.
module furv_rr_pick #(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             any
);

    int unsigned j;

    // Walk NREQ slots from ptr, taking the first valid one.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        j         = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            j = 32'(ptr) + off;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!any && valid[j[PTR_W-1:0]]) begin
                any                   = 1'b1;
                grant[j[PTR_W-1:0]]   = 1'b1;
                grant_idx             = j[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/furv_wb_arb.sv
// furv_wb_arb: round-robin arbiter sharing the register-file write-back port
// among NREQ result producers, with a single registered output stage and a
// sticky duplicate-destination flag.
// Optional build macro FURV_WB_ARB_STATS_EN adds saturating per-requester
// grant counters (grant_cnt) and a multi-valid conflict counter (conflict_cnt).
module furv_wb_arb
    import furv_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned XLEN = furv_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    furv_wb_arb_if.slave         bus
`ifdef FURV_WB_ARB_STATS_EN
    ,
    output logic [16*NREQ-1:0]   grant_cnt,
    output logic [15:0]          conflict_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(NREQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  grant;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_any;
    logic             dup_hit;
    reg_idx_t         wb_rd_q;
    logic [XLEN-1:0]  wb_val_q;
    logic             wb_rdy_q;
    logic             err_q;

    furv_rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid     (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    assign bus.req_ready   = grant;
    assign bus.wb_rel_rd   = wb_rd_q;
    assign bus.wb_rd_value = wb_val_q;
    assign bus.wb_rd_ready = wb_rdy_q;
    assign bus.err_dup_rd  = err_q;

    // Pointer moves one past the winner; rr_next holds it when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= PTR_W'(rr_next(32'(rr_ptr), MAX_REQ'(grant), NREQ));
        end
    end

    // Output stage: capture the winner's rd/value; strobe only on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_rd_q  <= '0;
            wb_val_q <= '0;
            wb_rdy_q <= 1'b0;
        end else begin
            wb_rdy_q <= grant_any;
            if (grant_any) begin
                wb_rd_q  <= bus.req_rd[REG_IDX_W*grant_idx +: REG_IDX_W];
                wb_val_q <= bus.req_value[XLEN*grant_idx +: XLEN];
            end
        end
    end

    // Two valid requesters aiming at the same nonzero rd in one cycle.
    always_comb begin
        dup_hit = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            for (int unsigned k = i + 1; k < NREQ; k++) begin
                if (bus.req_valid[i] && bus.req_valid[k] &&
                    (bus.req_rd[REG_IDX_W*i +: REG_IDX_W] == bus.req_rd[REG_IDX_W*k +: REG_IDX_W]) &&
                    (bus.req_rd[REG_IDX_W*i +: REG_IDX_W] != '0)) begin
                    dup_hit = 1'b1;
                end
            end
        end
    end

    // Sticky duplicate flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (dup_hit) begin
            err_q <= 1'b1;
        end
    end

`ifdef FURV_WB_ARB_STATS_EN
    logic [15:0] gcnt_q [NREQ];
    logic [15:0] conflict_q;
    logic        multi_valid;
    int unsigned n_valid;

    // More than one requester valid this cycle.
    always_comb begin
        n_valid = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            n_valid = n_valid + 32'(bus.req_valid[i]);
        end
        multi_valid = (n_valid >= 2);
    end

    // Saturating per-requester grant counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                gcnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i] && (gcnt_q[i] != '1)) begin
                    gcnt_q[i] <= gcnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Saturating count of multi-valid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (multi_valid && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    // Flatten the counters onto the output bus, requester i at [16*i+:16].
    always_comb begin
        grant_cnt = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant_cnt[16*i +: 16] = gcnt_q[i];
        end
    end

    assign conflict_cnt = conflict_q;
`else
`endif

endmodule

// File: tb/tb_furv_wb_arb.sv
// tb_furv_wb_arb: directed table-driven bench for furv_wb_arb (NREQ=3),
// with hand-written sequences for single requester, duplicate rd, mid-stream
// reset and the optional statistics counters.
module tb_furv_wb_arb;
    import furv_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned W    = 32;
    localparam logic [31:0] C0   = 32'h1111_1111;
    localparam logic [31:0] C1   = 32'h2222_2222;
    localparam logic [31:0] C2   = 32'h3333_3333;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    furv_wb_arb_if #(.NREQ(NREQ), .XLEN(W)) bus ();

`ifdef FURV_WB_ARB_STATS_EN
    logic [16*NREQ-1:0] grant_cnt;
    logic [15:0]        conflict_cnt;
`endif

    furv_wb_arb #(
        .NREQ (NREQ),
        .XLEN (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FURV_WB_ARB_STATS_EN
        ,
        .grant_cnt    (grant_cnt),
        .conflict_cnt (conflict_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0]  valid;
        logic [4:0]  rd0, rd1, rd2;
        logic [2:0]  exp_ready;
        logic        exp_wbr;
        logic [4:0]  exp_rd;
        logic [31:0] exp_val;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [4:0] r0, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2);
        bus.req_valid = v;
        bus.req_rd    = {r2, r1, r0};
        bus.req_value = {d2, d1, d0};
    endtask

    task automatic check_wb(input string tag, input logic rdy, input logic [4:0] rd,
                            input logic [31:0] val);
        check({tag, ".wb_rd_ready"}, 64'(bus.wb_rd_ready), 64'(rdy));
        check({tag, ".wb_rel_rd"},   64'(bus.wb_rel_rd),   64'(rd));
        check({tag, ".wb_rd_value"}, 64'(bus.wb_rd_value), 64'(val));
    endtask

    initial begin
        // pointer starts at 0; comments give pointer before each vector
        tbl[0] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, C0}; // p0
        tbl[1] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, C1}; // p1
        tbl[2] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, C2}; // p2
        tbl[3] = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd1, C0}; // p0
        tbl[4] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd1, C0}; // p1 idle, hold
        tbl[5] = '{3'b001, 5'd9, 5'd2, 5'd3, 3'b001, 1'b1, 5'd9, C0}; // p1 skip to 0
        tbl[6] = '{3'b011, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, C1}; // p1
        tbl[7] = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd3, C2}; // p2
        tbl[8] = '{3'b110, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd2, C1}; // p0
        tbl[9] = '{3'b011, 5'd4, 5'd2, 5'd3, 3'b001, 1'b1, 5'd4, C0}; // p2 wraps to 0

        rst_n = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        #12;
        check_wb("reset", 1'b0, 5'd0, 32'd0);
        check("reset.err_dup_rd", 64'(bus.err_dup_rd), 64'd0);
        check("reset.req_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(tbl[i].valid, tbl[i].rd0, tbl[i].rd1, tbl[i].rd2, C0, C1, C2);
            #1;
            check($sformatf("vec%0d.req_ready", i), 64'(bus.req_ready), 64'(tbl[i].exp_ready));
            @(posedge clk);
            #1;
            check_wb($sformatf("vec%0d", i), tbl[i].exp_wbr, tbl[i].exp_rd, tbl[i].exp_val);
            check($sformatf("vec%0d.err_dup_rd", i), 64'(bus.err_dup_rd), 64'd0);
        end
        // pointer is now 1

        // single requester 2, one cycle
        @(negedge clk);
        drive(3'b100, 5'd0, 5'd0, 5'd5, C0, C1, 32'hDEAD_BEEF);
        #1;
        check("single.req_ready", 64'(bus.req_ready), 64'b100);
        @(posedge clk);
        #1;
        check_wb("single.hit", 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        #1;
        check("single.idle_ready", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        #1;
        check_wb("single.after", 1'b0, 5'd5, 32'hDEAD_BEEF);
        // pointer is now 0

        // duplicate rd=0: no error, both written
        @(negedge clk);
        drive(3'b011, 5'd0, 5'd0, 5'd3, C0, C1, C2);
        #1;
        check("dup0.ready_a", 64'(bus.req_ready), 64'b001);
        @(posedge clk);
        #1;
        check_wb("dup0.a", 1'b1, 5'd0, C0);
        check("dup0.err_a", 64'(bus.err_dup_rd), 64'd0);
        @(negedge clk);
        drive(3'b010, 5'd0, 5'd0, 5'd3, C0, C1, C2);
        #1;
        check("dup0.ready_b", 64'(bus.req_ready), 64'b010);
        @(posedge clk);
        #1;
        check_wb("dup0.b", 1'b1, 5'd0, C1);
        check("dup0.err_b", 64'(bus.err_dup_rd), 64'd0);
        // pointer is now 2

        // duplicate rd=7: sticky error, both written in order 0 then 1
        @(negedge clk);
        drive(3'b011, 5'd7, 5'd7, 5'd3, C0, C1, C2);
        #1;
        check("dup7.ready_a", 64'(bus.req_ready), 64'b001);
        @(posedge clk);
        #1;
        check_wb("dup7.a", 1'b1, 5'd7, C0);
        check("dup7.err_a", 64'(bus.err_dup_rd), 64'd1);
        @(negedge clk);
        drive(3'b010, 5'd7, 5'd7, 5'd3, C0, C1, C2);
        #1;
        check("dup7.ready_b", 64'(bus.req_ready), 64'b010);
        @(posedge clk);
        #1;
        check_wb("dup7.b", 1'b1, 5'd7, C1);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        @(posedge clk);
        #1;
        check("dup7.sticky", 64'(bus.err_dup_rd), 64'd1);
        check_wb("dup7.idle", 1'b0, 5'd7, C1);
        // pointer is now 2

        // reset while a grant is in flight
        @(negedge clk);
        drive(3'b111, 5'd1, 5'd2, 5'd3, C0, C1, C2);
        @(posedge clk);
        #1;
        check_wb("rst.before", 1'b1, 5'd3, C2);
        #2;
        rst_n = 1'b0;
        #1;
        check_wb("rst.async", 1'b0, 5'd0, 32'd0);
        check("rst.async_err", 64'(bus.err_dup_rd), 64'd0);
        check("rst.ptr_ready", 64'(bus.req_ready), 64'b001);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.first_ready", 64'(bus.req_ready), 64'b001);
        @(posedge clk);
        #1;
        check_wb("rst.first", 1'b1, 5'd1, C0);

`ifdef FURV_WB_ARB_STATS_EN
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        #1;
        check("stats.rst_grant", 64'(grant_cnt), 64'd0);
        check("stats.rst_conflict", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b111, 5'd1, 5'd2, 5'd3, C0, C1, C2);
        repeat (4) @(posedge clk);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
        @(posedge clk);
        #1;
        check("stats.grant_cnt", 64'(grant_cnt), 64'({16'd1, 16'd1, 16'd2}));
        check("stats.conflict_cnt", 64'(conflict_cnt), 64'd4);
        @(negedge clk);
        force dut.conflict_q = 16'hFFFF;
        #1;
        release dut.conflict_q;
        drive(3'b011, 5'd1, 5'd2, 5'd3, C0, C1, C2);
        @(posedge clk);
        #1;
        check("stats.conflict_sat", 64'(conflict_cnt), 64'hFFFF);
        @(negedge clk);
        drive(3'b000, 5'd0, 5'd0, 5'd0, '0, '0, '0);
`endif

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
